// File: rtl/sugar_store.sv
// sugar_store: multi-unit sugar bank for the ant grid.
//
// Holds a SUGAR_W-bit sugar count for each of LOC_NUM locations. Each accepted
// update performs a read-modify-write: ants that want sugar are granted one unit
// each, lowest index first, limited by the stored count. Placed sugar is then
// added with saturation at SMAX, and the result is reported two cycles after
// the accept edge.
//
// Ports:
//   Clk            in   system clock, rising edge
//   Reset          in   synchronous active-high reset
//   upd_valid      in   update request present
//   upd_ready      out  request accepted when high (only in RUN)
//   upd_loc        in   location being updated
//   isUpdating     in   per-ant: ant is part of this update
//   ant_acquiring  in   per-ant: ant wants one unit of sugar
//   place_amt      in   sugar units placed at upd_loc
//   res_valid      out  one-cycle result strobe per accepted request
//   res_loc        out  location of the result
//   res_grant      out  ants granted one unit each
//   res_sugar      out  new count written back
//   res_has_sugar  out  res_sugar != 0 (replaces the legacy 1-bit flag)
//   res_sat        out  addition was clipped at SMAX
//   init_done      out  memory clear complete
module sugar_store #(
  parameter int ANT_NUM = 8,
  parameter int LOC_NUM = 1024,
  parameter int SUGAR_W = 4,
  localparam int LOC_W = $clog2(LOC_NUM)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [LOC_W-1:0]   upd_loc,
  input  logic [ANT_NUM-1:0] isUpdating,
  input  logic [ANT_NUM-1:0] ant_acquiring,
  input  logic [SUGAR_W-1:0] place_amt,
  output logic               res_valid,
  output logic [LOC_W-1:0]   res_loc,
  output logic [ANT_NUM-1:0] res_grant,
  output logic [SUGAR_W-1:0] res_sugar,
  output logic               res_has_sugar,
  output logic               res_sat,
  output logic               init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [SUGAR_W-1:0] SMAX     = {SUGAR_W{1'b1}};
  localparam logic [SUGAR_W:0]   SMAX_EXT = {1'b0, SMAX};
  localparam logic [SUGAR_W:0]   ONE_EXT  = (SUGAR_W+1)'(1);
  localparam logic [LOC_W-1:0]   LAST_LOC = LOC_W'(LOC_NUM - 1);
  localparam logic [LOC_W-1:0]   ONE_LOC  = LOC_W'(1);

  // Grant the lowest-index requesters, at most cur of them.
  function automatic logic [ANT_NUM-1:0] grant_lowest(input logic [ANT_NUM-1:0] want,
                                                       input logic [SUGAR_W-1:0] cur);
    logic [SUGAR_W:0] cnt;
    grant_lowest = '0;
    cnt = '0;
    for (int i = 0; i < ANT_NUM; i++) begin
      if (want[i] && (cnt < {1'b0, cur})) begin
        grant_lowest[i] = 1'b1;
        cnt = cnt + ONE_EXT;
      end else begin
        grant_lowest[i] = 1'b0;
      end
    end
  endfunction

  // Number of grants; never exceeds cur, so SUGAR_W+1 bits always suffice.
  function automatic logic [SUGAR_W:0] grant_count(input logic [ANT_NUM-1:0] grant);
    grant_count = '0;
    for (int i = 0; i < ANT_NUM; i++) begin
      if (grant[i]) begin
        grant_count = grant_count + ONE_EXT;
      end else begin
        grant_count = grant_count;
      end
    end
  endfunction

  logic [SUGAR_W-1:0] mem_q [LOC_NUM];

  state_e             state_q, state_d;
  logic [LOC_W-1:0]   init_addr_q, init_addr_d;
  logic               upd_ready_q, upd_ready_d;
  logic               init_done_q, init_done_d;

  logic               s0_valid_q, s0_valid_d;
  logic [LOC_W-1:0]   s0_loc_q, s0_loc_d;
  logic [ANT_NUM-1:0] s0_want_q, s0_want_d;
  logic [SUGAR_W-1:0] s0_place_q, s0_place_d;

  logic               s1_valid_q, s1_valid_d;
  logic [LOC_W-1:0]   s1_loc_q, s1_loc_d;
  logic [ANT_NUM-1:0] s1_want_q, s1_want_d;
  logic [SUGAR_W-1:0] s1_place_q, s1_place_d;
  logic [SUGAR_W-1:0] s1_cur_q, s1_cur_d;

  logic               res_valid_q, res_valid_d;
  logic [LOC_W-1:0]   res_loc_q, res_loc_d;
  logic [ANT_NUM-1:0] res_grant_q, res_grant_d;
  logic [SUGAR_W-1:0] res_sugar_q, res_sugar_d;
  logic               res_has_q, res_has_d;
  logic               res_sat_q, res_sat_d;

  logic               accept;
  logic [SUGAR_W-1:0] rd_data;
  logic [ANT_NUM-1:0] s1_grant;
  logic [SUGAR_W:0]   s1_g;
  logic [SUGAR_W:0]   s1_sum;
  logic               s1_sat;
  logic [SUGAR_W-1:0] s1_new;
  logic               mem_we;
  logic [LOC_W-1:0]   mem_wa;
  logic [SUGAR_W-1:0] mem_wd;

  // S1 arithmetic: pickups come out of the stored count before placement is added.
  always_comb begin
    s1_grant = grant_lowest(s1_want_q, s1_cur_q);
    s1_g     = grant_count(s1_grant);
    s1_sum   = {1'b0, s1_cur_q} - s1_g + {1'b0, s1_place_q};
    s1_sat   = (s1_sum > SMAX_EXT);
    if (s1_sat) begin
      s1_new = SMAX;
    end else begin
      s1_new = s1_sum[SUGAR_W-1:0];
    end
  end

  // Memory write port: INIT clears one entry per cycle, RUN writes back S1.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = s1_loc_q;
    mem_wd = s1_new;
    if (Reset) begin
      mem_we = 1'b0;
    end else if (state_q == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_addr_q;
      mem_wd = '0;
    end else if (s1_valid_q) begin
      mem_we = 1'b1;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Sugar count storage (contents are established by INIT, not by reset).
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign rd_data = mem_q[s0_loc_q];
  assign accept  = upd_valid & upd_ready_q;

  // Next-state logic for the FSM, the two pipeline stages and the result registers.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    upd_ready_d = upd_ready_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ONE_LOC;
        if (init_addr_q == LAST_LOC) begin
          state_d     = ST_RUN;
          upd_ready_d = 1'b1;
          init_done_d = 1'b1;
        end else begin
          upd_ready_d = 1'b0;
          init_done_d = 1'b0;
        end
      end
      ST_RUN: begin
        upd_ready_d = 1'b1;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
        upd_ready_d = 1'b0;
        init_done_d = 1'b0;
      end
    endcase

    s0_valid_d = accept;
    if (accept) begin
      s0_loc_d   = upd_loc;
      s0_want_d  = isUpdating & ant_acquiring;
      s0_place_d = place_amt;
    end else begin
      s0_loc_d   = s0_loc_q;
      s0_want_d  = s0_want_q;
      s0_place_d = s0_place_q;
    end

    // The S1 write lands on the same edge as this read, so bypass it when the
    // addresses match; this keeps back-to-back updates to one location exact.
    s1_valid_d = s0_valid_q;
    s1_loc_d   = s0_loc_q;
    s1_want_d  = s0_want_q;
    s1_place_d = s0_place_q;
    if (s1_valid_q && (s1_loc_q == s0_loc_q)) begin
      s1_cur_d = s1_new;
    end else begin
      s1_cur_d = rd_data;
    end

    res_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      res_loc_d   = s1_loc_q;
      res_grant_d = s1_grant;
      res_sugar_d = s1_new;
      res_has_d   = (s1_new != '0);
      res_sat_d   = s1_sat;
    end else begin
      res_loc_d   = res_loc_q;
      res_grant_d = res_grant_q;
      res_sugar_d = res_sugar_q;
      res_has_d   = res_has_q;
      res_sat_d   = res_sat_q;
    end
  end

  // All control and datapath registers, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      upd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_loc_q    <= '0;
      s0_want_q   <= '0;
      s0_place_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_loc_q    <= '0;
      s1_want_q   <= '0;
      s1_place_q  <= '0;
      s1_cur_q    <= '0;
      res_valid_q <= 1'b0;
      res_loc_q   <= '0;
      res_grant_q <= '0;
      res_sugar_q <= '0;
      res_has_q   <= 1'b0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      upd_ready_q <= upd_ready_d;
      init_done_q <= init_done_d;
      s0_valid_q  <= s0_valid_d;
      s0_loc_q    <= s0_loc_d;
      s0_want_q   <= s0_want_d;
      s0_place_q  <= s0_place_d;
      s1_valid_q  <= s1_valid_d;
      s1_loc_q    <= s1_loc_d;
      s1_want_q   <= s1_want_d;
      s1_place_q  <= s1_place_d;
      s1_cur_q    <= s1_cur_d;
      res_valid_q <= res_valid_d;
      res_loc_q   <= res_loc_d;
      res_grant_q <= res_grant_d;
      res_sugar_q <= res_sugar_d;
      res_has_q   <= res_has_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign upd_ready     = upd_ready_q;
  assign init_done     = init_done_q;
  assign res_valid     = res_valid_q;
  assign res_loc       = res_loc_q;
  assign res_grant     = res_grant_q;
  assign res_sugar     = res_sugar_q;
  assign res_has_sugar = res_has_q;
  assign res_sat       = res_sat_q;

endmodule

// File: tb/tb_sugar_store.sv
// tb_sugar_store: directed scoreboard bench for sugar_store (default parameters).
module tb_sugar_store;

  localparam int LOC_NUM = 1024;

  logic       Clk;
  logic       Reset;
  logic       upd_valid;
  logic       upd_ready;
  logic [9:0] upd_loc;
  logic [7:0] is_updating;
  logic [7:0] ant_acquiring;
  logic [3:0] place_amt;
  logic       res_valid;
  logic [9:0] res_loc;
  logic [7:0] res_grant;
  logic [3:0] res_sugar;
  logic       res_has_sugar;
  logic       res_sat;
  logic       init_done;

  typedef struct {
    logic [9:0] loc;
    logic [7:0] grant;
    logic [3:0] sugar;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  sugar_store dut (
    .Clk(Clk),
    .Reset(Reset),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_loc(upd_loc),
    .isUpdating(is_updating),
    .ant_acquiring(ant_acquiring),
    .place_amt(place_amt),
    .res_valid(res_valid),
    .res_loc(res_loc),
    .res_grant(res_grant),
    .res_sugar(res_sugar),
    .res_has_sugar(res_has_sugar),
    .res_sat(res_sat),
    .init_done(init_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a result appears.
  always @(negedge Clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_latency", cyc, e.cyc);
        check("res_loc", res_loc, e.loc);
        check("res_grant", res_grant, e.grant);
        check("res_sugar", res_sugar, e.sugar);
        check("res_has_sugar", res_has_sugar, (e.sugar != 4'd0));
        check("res_sat", res_sat, e.sat);
      end
    end
  end

  // Drive one request for one cycle and record its expected result.
  task automatic issue(input logic [9:0] loc, input logic [7:0] isu, input logic [7:0] acq,
                       input logic [3:0] place, input logic [7:0] eg, input logic [3:0] es,
                       input logic esat);
    exp_t e;
    upd_valid     = 1'b1;
    upd_loc       = loc;
    is_updating   = isu;
    ant_acquiring = acq;
    place_amt     = place;
    e.loc = loc; e.grant = eg; e.sugar = es; e.sat = esat; e.cyc = cyc + 3;
    sb.push_back(e);
    @(posedge Clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    upd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1;
    end
  endtask

  // Count the not-ready cycles of INIT; optionally offer a request that must be dropped.
  task automatic wait_init(input logic offer);
    int  zeros;
    bit  done;
    zeros = 0;
    done  = 1'b0;
    if (offer) begin
      upd_valid = 1'b1; upd_loc = 10'd4; is_updating = 8'hFF;
      ant_acquiring = 8'hFF; place_amt = 4'd7;
    end else begin
      upd_valid = 1'b0;
    end
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge Clk);
      if (k == 0) begin
        check("rst_upd_ready", upd_ready, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_sugar", res_sugar, 4'd0);
        check("rst_res_grant", res_grant, 8'd0);
        check("rst_res_loc", res_loc, 10'd0);
        check("rst_res_sat", res_sat, 1'b0);
        check("rst_res_has", res_has_sugar, 1'b0);
      end
      if (upd_ready === 1'b1) done = 1'b1;
      else zeros++;
    end
    upd_valid = 1'b0;
    check("init_len", zeros, LOC_NUM);
    check("init_done", init_done, 1'b1);
    @(posedge Clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge Clk);
    check("drain_empty", sb.size(), 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; upd_valid = 1'b0; upd_loc = '0; is_updating = '0;
    ant_acquiring = '0; place_amt = '0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wait_init(1'b0);

    // Read-only update after clear.
    issue(10'd9, 8'h00, 8'h00, 4'd0, 8'h00, 4'd0, 1'b0);
    // Placement followed immediately by pickups at the same location (forwarding).
    issue(10'd5, 8'h00, 8'h00, 4'd3, 8'h00, 4'd3, 1'b0);
    issue(10'd5, 8'hFF, 8'b1011_0110, 4'd0, 8'b0001_0110, 4'd0, 1'b0);
    idle(2);
    // Saturation, then a pickup chained through the clipped value.
    issue(10'd7, 8'h00, 8'h00, 4'd14, 8'h00, 4'd14, 1'b0);
    idle(3);
    issue(10'd7, 8'h00, 8'h00, 4'd5, 8'h00, 4'd15, 1'b1);
    issue(10'd7, 8'hFF, 8'h01, 4'd0, 8'h01, 4'd14, 1'b0);
    idle(2);
    // Placement is not available to the same request's pickups.
    issue(10'd3, 8'h00, 8'h00, 4'd2, 8'h00, 4'd2, 1'b0);
    issue(10'd3, 8'b0000_0011, 8'hFF, 4'd4, 8'h03, 4'd4, 1'b0);
    // isUpdating=0 gives no grants.
    issue(10'd3, 8'h00, 8'hFF, 4'd0, 8'h00, 4'd4, 1'b0);
    // cur=0 gives no grants.
    issue(10'd11, 8'hFF, 8'hFF, 4'd1, 8'h00, 4'd1, 1'b0);
    drain();

    // Streaming: alternate locations 1 and 2, one unit each.
    for (int j = 0; j < 20; j++) begin
      issue((j % 2 == 0) ? 10'd1 : 10'd2, 8'h00, 8'h00, 4'd1, 8'h00, 4'(j / 2 + 1), 1'b0);
    end
    idle(2);
    issue(10'd1, 8'h00, 8'h00, 4'd0, 8'h00, 4'd10, 1'b0);
    issue(10'd2, 8'h00, 8'h00, 4'd0, 8'h00, 4'd10, 1'b0);
    drain();

    // Reset one cycle after an accept: the request must vanish.
    upd_valid = 1'b1; upd_loc = 10'd1; is_updating = 8'h00;
    ant_acquiring = 8'h00; place_amt = 4'd1;
    @(posedge Clk); #1;
    upd_valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wait_init(1'b1);
    issue(10'd1, 8'h00, 8'h00, 4'd0, 8'h00, 4'd0, 1'b0);
    issue(10'd5, 8'hFF, 8'hFF, 4'd0, 8'h00, 4'd0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
